// File: rtl/t2mi_sched_pkg.sv
// Shared types for the T2-MI packet scheduler: FSM state encoding and T2-MI packet_type codes.
package t2mi_sched_pkg;

  typedef enum logic [2:0] {S_IDLE, S_BB, S_TS, S_L1, S_NEXT} state_e;

  localparam logic [7:0] PKT_BB = 8'h00;
  localparam logic [7:0] PKT_TS = 8'h20;
  localparam logic [7:0] PKT_L1 = 8'h10;

endpackage

// File: rtl/t2mi_sched_watchdog.sv
// Grant-hold watchdog: counts enabled cycles and flags the last permitted cycle of a grant.
module t2mi_sched_watchdog #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i)  cnt_q <= cnt_q + CW'(1);
  end

  // Expires on the TIMEOUT_CYCLES-th held cycle so the grant is high exactly that long.
  assign expire_o = en_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/t2mi_packet_scheduler.sv
// Per-frame T2-MI packet scheduler (BBFrames, timestamp, L1-current) with frame/superframe/packet counters.
// Define T2MI_TIMESTAMP_EN to include the timestamp packet slot; otherwise BB goes straight to L1.
module t2mi_packet_scheduler
  import t2mi_sched_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [9:0] plp_num_blocks,
  input  logic [7:0] num_t2_frames,
  input  logic       BB_REQ,
  input  logic       TS_REQ,
  input  logic       L1_REQ,
  input  logic       PKT_DONE,
  output logic       GRANT_BB,
  output logic       GRANT_TS,
  output logic       GRANT_L1,
  output logic [7:0] PKT_TYPE,
  output logic [7:0] PKT_COUNT,
  output logic [7:0] FRAME_IDX,
  output logic [3:0] SUPERFRAME_IDX,
  output logic       TIMEOUT_ERR
);
  state_e     state_q;
  logic [2:0] grant_q;  // {BB, TS, L1}
  logic [9:0] blk_q, nblk_q;
  logic [7:0] nfrm_q, frame_q, type_q, cnt_q;
  logic [3:0] sf_q;
  logic       err_q;

  logic       granted, expire, finish, req_sel, sf_wrap, to_idle;
  logic [7:0] nfrm_eff;
  logic [9:0] nblk_nx;

`ifdef T2MI_TIMESTAMP_EN
  localparam state_e S_AFTER_BB = S_TS;
  assign GRANT_TS = grant_q[1];
`else
  localparam state_e S_AFTER_BB = S_L1;
  logic ts_unused;
  assign ts_unused = TS_REQ | grant_q[1];
  assign GRANT_TS  = 1'b0;
`endif

  assign granted  = |grant_q;
  assign finish   = granted & (PKT_DONE | expire);
  assign nfrm_eff = (nfrm_q == 8'd0) ? 8'd1 : nfrm_q;
  assign sf_wrap  = (frame_q >= nfrm_eff - 8'd1);
  // New superframe takes the freshly reloaded block count.
  assign nblk_nx  = sf_wrap ? plp_num_blocks : nblk_q;
  assign to_idle  = (state_q != S_IDLE) && !START && (!granted || finish);

  always_comb begin
    req_sel = 1'b0;
    case (state_q)
      S_BB:    req_sel = BB_REQ;
`ifdef T2MI_TIMESTAMP_EN
      S_TS:    req_sel = TS_REQ;
`endif
      S_L1:    req_sel = L1_REQ;
      default: req_sel = 1'b0;
    endcase
  end

  t2mi_sched_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clk      (CLK),
    .rst_n    (RST),
    .clr_i    (!granted || finish),
    .en_i     (granted),
    .expire_o (expire)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      blk_q   <= '0;
      nblk_q  <= '0;
      nfrm_q  <= '0;
      frame_q <= '0;
      sf_q    <= '0;
      type_q  <= PKT_BB;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      // A timed-out grant advances the schedule but consumes no packet_count value.
      if (finish) begin
        grant_q <= '0;
        if (PKT_DONE) cnt_q <= cnt_q + 8'd1;
        else          err_q <= 1'b1;
      end
      if (to_idle) begin
        state_q <= S_IDLE;
        frame_q <= '0;
        sf_q    <= '0;
        blk_q   <= '0;
      end else begin
        case (state_q)
          S_IDLE: if (START) begin
            nblk_q  <= plp_num_blocks;
            nfrm_q  <= num_t2_frames;
            blk_q   <= '0;
            state_q <= (plp_num_blocks == 10'd0) ? S_AFTER_BB : S_BB;
          end
          S_NEXT: begin
            blk_q <= '0;
            if (sf_wrap) begin
              frame_q <= '0;
              sf_q    <= sf_q + 4'd1;
              nblk_q  <= plp_num_blocks;
              nfrm_q  <= num_t2_frames;
            end else begin
              frame_q <= frame_q + 8'd1;
            end
            state_q <= (nblk_nx == 10'd0) ? S_AFTER_BB : S_BB;
          end
          default: begin
            if (finish) begin
              case (state_q)
                S_BB: begin
                  blk_q <= blk_q + 10'd1;
                  if (blk_q + 10'd1 == nblk_q) state_q <= S_AFTER_BB;
                end
                S_L1:    state_q <= S_NEXT;
                default: state_q <= S_L1;
              endcase
            end else if (!granted && req_sel) begin
              case (state_q)
                S_BB: begin grant_q <= 3'b100; type_q <= PKT_BB; end
`ifdef T2MI_TIMESTAMP_EN
                S_TS: begin grant_q <= 3'b010; type_q <= PKT_TS; end
`endif
                default: begin grant_q <= 3'b001; type_q <= PKT_L1; end
              endcase
            end
          end
        endcase
      end
    end
  end

  assign GRANT_BB       = grant_q[2];
  assign GRANT_L1       = grant_q[0];
  assign PKT_TYPE       = type_q;
  assign PKT_COUNT      = cnt_q;
  assign FRAME_IDX      = frame_q;
  assign SUPERFRAME_IDX = sf_q;
  assign TIMEOUT_ERR    = err_q;

endmodule

// File: tb/tb_t2mi_packet_scheduler.sv
// Self-checking bench for t2mi_packet_scheduler; expected schedule derived from per-frame slot arithmetic.
module tb_t2mi_packet_scheduler;
  localparam int TO = 16;
`ifdef T2MI_TIMESTAMP_EN
  localparam int TSEN = 1;
`else
  localparam int TSEN = 0;
`endif

  logic       CLK = 1'b0, RST = 1'b0, START = 1'b0, PKT_DONE = 1'b0;
  logic       BB_REQ = 1'b0, TS_REQ = 1'b0, L1_REQ = 1'b0;
  logic [9:0] plp_num_blocks = '0;
  logic [7:0] num_t2_frames = '0;
  logic       GRANT_BB, GRANT_TS, GRANT_L1, TIMEOUT_ERR;
  logic [7:0] PKT_TYPE, PKT_COUNT, FRAME_IDX;
  logic [3:0] SUPERFRAME_IDX;

  int n_checks = 0, n_pass = 0, m_cnt = 0, onehot_err = 0, ts_seen = 0;

  always #5 CLK = ~CLK;

  t2mi_packet_scheduler #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RST(RST), .START(START), .plp_num_blocks(plp_num_blocks), .num_t2_frames(num_t2_frames),
    .BB_REQ(BB_REQ), .TS_REQ(TS_REQ), .L1_REQ(L1_REQ), .PKT_DONE(PKT_DONE),
    .GRANT_BB(GRANT_BB), .GRANT_TS(GRANT_TS), .GRANT_L1(GRANT_L1), .PKT_TYPE(PKT_TYPE), .PKT_COUNT(PKT_COUNT),
    .FRAME_IDX(FRAME_IDX), .SUPERFRAME_IDX(SUPERFRAME_IDX), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always @(negedge CLK) begin
    if ($countones({GRANT_BB, GRANT_TS, GRANT_L1}) > 1) onehot_err++;
    if (GRANT_TS) ts_seen++;
  end

  task automatic do_reset();
    RST = 1'b0; START = 1'b0; PKT_DONE = 1'b0; BB_REQ = 1'b0; TS_REQ = 1'b0; L1_REQ = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    m_cnt = 0;
  endtask

  task automatic wait_grant(output int cyc);
    cyc = -1;
    for (int k = 1; k <= 64; k++) begin
      @(posedge CLK); @(negedge CLK);
      if (GRANT_BB | GRANT_TS | GRANT_L1) begin cyc = k; break; end
    end
  endtask

  // Reference: a frame is nblk BB slots, an optional TS slot, then one L1 slot.
  task automatic run_seq(input int nblk, input int nfrm, input int npk, input bit rnd);
    int spf, efr, slot, frame, sf, gap, exp_gap, d;
    logic [2:0] exp_g;
    logic [7:0] exp_t;
    spf = nblk + TSEN + 1;
    efr = (nfrm == 0) ? 1 : nfrm;
    slot = 0; frame = 0; sf = 0; exp_gap = 2;
    plp_num_blocks = 10'(nblk); num_t2_frames = 8'(nfrm);
    BB_REQ = 1'b1; TS_REQ = 1'b1; L1_REQ = 1'b1; START = 1'b1;
    for (int p = 0; p < npk; p++) begin
      if (slot < nblk)                      begin exp_g = 3'b100; exp_t = 8'h00; end
      else if (TSEN == 1 && slot == nblk)   begin exp_g = 3'b010; exp_t = 8'h20; end
      else                                  begin exp_g = 3'b001; exp_t = 8'h10; end
      wait_grant(gap);
      n_checks++; if (gap !== exp_gap) $display("FAIL seq_gap p%0d: got %0d want %0d", p, gap, exp_gap); else n_pass++;
      n_checks++; if ({GRANT_BB, GRANT_TS, GRANT_L1} !== exp_g) $display("FAIL seq_grant p%0d: got %b want %b", p, {GRANT_BB, GRANT_TS, GRANT_L1}, exp_g); else n_pass++;
      n_checks++; if (PKT_TYPE !== exp_t) $display("FAIL seq_type p%0d: got %h want %h", p, PKT_TYPE, exp_t); else n_pass++;
      n_checks++; if (PKT_COUNT !== 8'(m_cnt)) $display("FAIL seq_count p%0d: got %0d want %0d", p, PKT_COUNT, m_cnt); else n_pass++;
      n_checks++; if (FRAME_IDX !== 8'(frame)) $display("FAIL seq_frame p%0d: got %0d want %0d", p, FRAME_IDX, frame); else n_pass++;
      n_checks++; if (SUPERFRAME_IDX !== 4'(sf)) $display("FAIL seq_sf p%0d: got %0d want %0d", p, SUPERFRAME_IDX, sf); else n_pass++;
      d = rnd ? int'($urandom_range(1, 6)) : 4;
      repeat (d) @(posedge CLK);
      #1 PKT_DONE = 1'b1;
      @(negedge CLK);
      n_checks++; if ({GRANT_BB, GRANT_TS, GRANT_L1} !== exp_g) $display("FAIL seq_hold p%0d: got %b want %b", p, {GRANT_BB, GRANT_TS, GRANT_L1}, exp_g); else n_pass++;
      @(posedge CLK);
      #1 PKT_DONE = 1'b0;
      @(negedge CLK);
      n_checks++; if ({GRANT_BB, GRANT_TS, GRANT_L1} !== 3'b000) $display("FAIL seq_drop p%0d: got %b want 000", p, {GRANT_BB, GRANT_TS, GRANT_L1}); else n_pass++;
      m_cnt = (m_cnt + 1) % 256;
      slot++;
      if (slot == spf) begin
        slot = 0; exp_gap = 2; frame++;
        if (frame == efr) begin frame = 0; sf = (sf + 1) % 16; end
      end else begin
        exp_gap = 1;
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b0; START = 1'b1; BB_REQ = 1'b1; TS_REQ = 1'b1; L1_REQ = 1'b1;
    plp_num_blocks = 10'd2; num_t2_frames = 8'd1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    @(negedge CLK);
    n_checks++; if ({GRANT_BB, GRANT_TS, GRANT_L1} !== 3'b000) $display("FAIL reset_grants: got %b want 000", {GRANT_BB, GRANT_TS, GRANT_L1}); else n_pass++;
    n_checks++; if (PKT_TYPE !== 8'h00) $display("FAIL reset_type: got %h want 00", PKT_TYPE); else n_pass++;
    n_checks++; if (PKT_COUNT !== 8'd0) $display("FAIL reset_count: got %0d want 0", PKT_COUNT); else n_pass++;
    n_checks++; if (FRAME_IDX !== 8'd0) $display("FAIL reset_frame: got %0d want 0", FRAME_IDX); else n_pass++;
    n_checks++; if (SUPERFRAME_IDX !== 4'd0) $display("FAIL reset_sf: got %0d want 0", SUPERFRAME_IDX); else n_pass++;
    n_checks++; if (TIMEOUT_ERR !== 1'b0) $display("FAIL reset_err: got %b want 0", TIMEOUT_ERR); else n_pass++;
    @(posedge CLK); @(negedge CLK);
    n_checks++; if ({GRANT_BB, GRANT_TS, GRANT_L1} !== 3'b000) $display("FAIL reset_first_cycle: got %b want 000", {GRANT_BB, GRANT_TS, GRANT_L1}); else n_pass++;
    @(posedge CLK); @(negedge CLK);
    n_checks++; if (GRANT_BB !== 1'b1) $display("FAIL reset_first_grant: got %b want 1", GRANT_BB); else n_pass++;
  endtask

  task automatic test_basic_frame();
    do_reset();
    run_seq(3, 2, 2 * (3 + TSEN + 1) + 2, 1'b0);
  endtask

  task automatic test_zero_blocks();
    do_reset();
    run_seq(0, 3, 3 * (TSEN + 1) + 1, 1'b0);
  endtask

  task automatic test_sf_wrap();
    do_reset();
    run_seq(0, 0, 17 * (TSEN + 1), 1'b1);
  endtask

  task automatic test_timeout();
    int gap, hi;
    logic [2:0] exp_g;
    do_reset();
    plp_num_blocks = 10'd2; num_t2_frames = 8'd1;
    BB_REQ = 1'b1; TS_REQ = 1'b1; L1_REQ = 1'b1; START = 1'b1;
    wait_grant(gap);
    n_checks++; if (GRANT_BB !== 1'b1) $display("FAIL to_first_grant: got %b want 1", GRANT_BB); else n_pass++;
    hi = 1;
    for (int k = 0; k < 40; k++) begin
      @(posedge CLK); @(negedge CLK);
      if (GRANT_BB) hi++; else break;
    end
    n_checks++; if (hi !== TO) $display("FAIL to_hold_cycles: got %0d want %0d", hi, TO); else n_pass++;
    n_checks++; if (TIMEOUT_ERR !== 1'b1) $display("FAIL to_err: got %b want 1", TIMEOUT_ERR); else n_pass++;
    n_checks++; if (PKT_COUNT !== 8'd0) $display("FAIL to_count: got %0d want 0", PKT_COUNT); else n_pass++;
    wait_grant(gap);
    n_checks++; if (gap !== 1) $display("FAIL to_next_gap: got %0d want 1", gap); else n_pass++;
    n_checks++; if (GRANT_BB !== 1'b1) $display("FAIL to_next_bb: got %b want 1", GRANT_BB); else n_pass++;
    n_checks++; if (PKT_COUNT !== 8'd0) $display("FAIL to_next_count: got %0d want 0", PKT_COUNT); else n_pass++;
    @(posedge CLK); #1 PKT_DONE = 1'b1;
    @(posedge CLK); #1 PKT_DONE = 1'b0;
    wait_grant(gap);
    exp_g = (TSEN == 1) ? 3'b010 : 3'b001;
    n_checks++; if ({GRANT_BB, GRANT_TS, GRANT_L1} !== exp_g) $display("FAIL to_after_blocks: got %b want %b", {GRANT_BB, GRANT_TS, GRANT_L1}, exp_g); else n_pass++;
    n_checks++; if (PKT_COUNT !== 8'd1) $display("FAIL to_after_count: got %0d want 1", PKT_COUNT); else n_pass++;
    n_checks++; if (TIMEOUT_ERR !== 1'b1) $display("FAIL to_err_sticky: got %b want 1", TIMEOUT_ERR); else n_pass++;
  endtask

  task automatic test_start_drop();
    int gap, seen, spf;
    spf = 3 + TSEN + 1;
    do_reset();
    run_seq(3, 2, spf, 1'b0);
    wait_grant(gap);
    n_checks++; if (GRANT_BB !== 1'b1) $display("FAIL sd_bb: got %b want 1", GRANT_BB); else n_pass++;
    n_checks++; if (FRAME_IDX !== 8'd1) $display("FAIL sd_frame1: got %0d want 1", FRAME_IDX); else n_pass++;
    @(posedge CLK); #1 START = 1'b0;
    @(posedge CLK); @(negedge CLK);
    n_checks++; if (GRANT_BB !== 1'b1) $display("FAIL sd_grant_kept: got %b want 1", GRANT_BB); else n_pass++;
    @(posedge CLK); #1 PKT_DONE = 1'b1;
    @(posedge CLK); #1 PKT_DONE = 1'b0;
    @(negedge CLK);
    n_checks++; if ({GRANT_BB, GRANT_TS, GRANT_L1} !== 3'b000) $display("FAIL sd_drop: got %b want 000", {GRANT_BB, GRANT_TS, GRANT_L1}); else n_pass++;
    n_checks++; if (FRAME_IDX !== 8'd0) $display("FAIL sd_frame_clr: got %0d want 0", FRAME_IDX); else n_pass++;
    n_checks++; if (PKT_COUNT !== 8'(spf + 1)) $display("FAIL sd_count: got %0d want %0d", PKT_COUNT, spf + 1); else n_pass++;
    seen = 0;
    repeat (6) begin
      @(posedge CLK); @(negedge CLK);
      if (GRANT_BB | GRANT_TS | GRANT_L1) seen++;
    end
    n_checks++; if (seen !== 0) $display("FAIL sd_idle_grants: got %0d want 0", seen); else n_pass++;
    START = 1'b1;
    wait_grant(gap);
    n_checks++; if (gap !== 2) $display("FAIL sd_restart_gap: got %0d want 2", gap); else n_pass++;
    n_checks++; if (GRANT_BB !== 1'b1) $display("FAIL sd_restart_bb: got %b want 1", GRANT_BB); else n_pass++;
    n_checks++; if (PKT_COUNT !== 8'(spf + 1)) $display("FAIL sd_restart_count: got %0d want %0d", PKT_COUNT, spf + 1); else n_pass++;
  endtask

  task automatic test_stray();
    int gap;
    do_reset();
    repeat (3) begin
      @(posedge CLK); #1 PKT_DONE = 1'b1;
      @(posedge CLK); #1 PKT_DONE = 1'b0;
    end
    @(negedge CLK);
    n_checks++; if (PKT_COUNT !== 8'd0) $display("FAIL stray_idle_count: got %0d want 0", PKT_COUNT); else n_pass++;
    n_checks++; if (FRAME_IDX !== 8'd0) $display("FAIL stray_idle_frame: got %0d want 0", FRAME_IDX); else n_pass++;
    plp_num_blocks = 10'd2; num_t2_frames = 8'd1;
    BB_REQ = 1'b1; TS_REQ = 1'b1; L1_REQ = 1'b1; START = 1'b1;
    wait_grant(gap);
    @(posedge CLK); #1 PKT_DONE = 1'b1;
    @(posedge CLK); @(negedge CLK);
    n_checks++; if (GRANT_BB !== 1'b0) $display("FAIL stray_gap_drop: got %b want 0", GRANT_BB); else n_pass++;
    @(posedge CLK); #1 PKT_DONE = 1'b0;
    @(negedge CLK);
    n_checks++; if (GRANT_BB !== 1'b1) $display("FAIL stray_gap_bb: got %b want 1", GRANT_BB); else n_pass++;
    n_checks++; if (PKT_COUNT !== 8'd1) $display("FAIL stray_gap_count: got %0d want 1", PKT_COUNT); else n_pass++;
    #2 RST = 1'b0;
    #1;
    n_checks++; if ({GRANT_BB, GRANT_TS, GRANT_L1} !== 3'b000) $display("FAIL async_grants: got %b want 000", {GRANT_BB, GRANT_TS, GRANT_L1}); else n_pass++;
    n_checks++; if (PKT_COUNT !== 8'd0) $display("FAIL async_count: got %0d want 0", PKT_COUNT); else n_pass++;
    START = 1'b0;
    @(posedge CLK); #1 RST = 1'b1;
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      do_reset();
      run_seq(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), int'($urandom_range(6, 18)), 1'b1);
    end
  endtask

  task automatic test_ts_config();
    do_reset();
    run_seq(2, 2, 2 * (2 + TSEN + 1), 1'b0);
    n_checks++; if ((ts_seen != 0) !== (TSEN == 1)) $display("FAIL ts_presence: got ts_seen=%0d want nonzero=%0d", ts_seen, TSEN); else n_pass++;
    n_checks++; if (onehot_err !== 0) $display("FAIL onehot: got %0d violations want 0", onehot_err); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_zero_blocks();
    test_sf_wrap();
    test_timeout();
    test_start_drop();
    test_stray();
    test_random();
    test_ts_config();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no end of run want finish");
    $fatal(1);
  end

endmodule

// File: doc/t2mi_packet_scheduler.md
# t2mi_packet_scheduler

Sequences T2-MI packet generation for one PLP. Per T2 frame it grants the shared packet-encapsulation path to three packet sources in a fixed order: BBFrame packets, the timestamp packet, and the L1-current packet. It also maintains the frame index, the superframe index and the 8-bit T2-MI packet counter that are carried in packet headers. It sits between the packet sources and the T2-MI-over-TS encapsulator and runs on the TS byte clock.

## Interface
Parameters:
- TIMEOUT_CYCLES, 4096, maximum cycles a grant may be held before it is aborted.

Ports:
- CLK  in  1  TS byte clock; single clock domain.
- RST  in  1  reset, asynchronous, active-low.
- START  in  1  level; scheduling is enabled while high (driven from input TS sync found).
- plp_num_blocks  in  10  BBFrames per T2 frame.
- num_t2_frames  in  8  T2 frames per superframe.
- BB_REQ / TS_REQ / L1_REQ  in  1 each  source has a packet ready; held until granted.
- PKT_DONE  in  1  one-cycle pulse from the granted source when its last byte has been accepted.
- GRANT_BB / GRANT_TS / GRANT_L1  out  1 each  one-hot grant; at most one is high.
- PKT_TYPE  out  8  type of the granted packet: 8'h00 BB, 8'h20 timestamp, 8'h10 L1-current.
- PKT_COUNT  out  8  T2-MI packet_count for the granted packet.
- FRAME_IDX  out  8  current T2 frame index within the superframe.
- SUPERFRAME_IDX  out  4  current superframe index.
- TIMEOUT_ERR  out  1  sticky flag; set when a grant times out.

## Operation
- States: IDLE, BB, TS, L1, NEXT.
- IDLE:
  - Waits for START.
  - On START, latches plp_num_blocks and num_t2_frames into shadow registers, then enters BB. If the latched block count is 0, enters TS instead.
  - The shadow registers are reloaded only in NEXT at a superframe boundary. Mid-superframe input changes are ignored.
- BB:
  - Grants BB_REQ once per block.
  - A 10-bit block counter increments on each PKT_DONE.
  - When it reaches the latched block count, the state moves to TS.
- TS: grants TS_REQ once, then moves to L1.
- L1: grants L1_REQ once, then moves to NEXT.
- NEXT (one cycle):
  - FRAME_IDX increments.
  - If FRAME_IDX was num_t2_frames−1, FRAME_IDX goes to 0, SUPERFRAME_IDX increments (15 wraps to 0) and the shadow registers reload.
  - num_t2_frames==0 is treated as 1.
  - Block counter clears. Next state is BB, or TS if the block count is 0.
- PKT_COUNT increments by 1 (mod 256) on every accepted PKT_DONE.
  - Its value during a grant is the count assigned to that packet.
  - The first packet after reset gets 0.
- PKT_DONE while no grant is high is ignored; no counters change.
- Timeout:
  - While a grant is high, a watchdog counts cycles.
  - At TIMEOUT_CYCLES without PKT_DONE, the grant drops and TIMEOUT_ERR sets.
  - Scheduling proceeds as if PKT_DONE had arrived, except that PKT_COUNT does not increment.
- START deasserting:
  - The current grant completes (by done or timeout).
  - The FSM then returns to IDLE, and FRAME_IDX, SUPERFRAME_IDX and the block counter clear.
  - PKT_COUNT and TIMEOUT_ERR are retained.
- Reset values: all grants 0, PKT_TYPE 8'h00, PKT_COUNT 0, FRAME_IDX 0, SUPERFRAME_IDX 0, TIMEOUT_ERR 0, state IDLE.

## Timing
- Grant latency: REQ high in a granting state at cycle n gives the grant registered high at n+1. PKT_TYPE and PKT_COUNT are valid in the same cycle as the grant.
- Grant hold: the grant stays high through the PKT_DONE cycle m and is low at m+1.
- Next grant: the earliest next grant is at m+2, a guaranteed one-cycle gap. When a frame ends, NEXT adds one further cycle.
- REQ and DONE together: REQ for the next packet may be high during the done cycle. It is sampled again after the gap.
- Counter update: counters update on the clock edge that samples PKT_DONE.
- Async reset: takes effect immediately on every flop. It releases synchronously with no grant in the first cycle.

## Configuration
- T2MI_TIMESTAMP_EN defined: the TS state is present and the timestamp packet is granted each frame.
- T2MI_TIMESTAMP_EN undefined:
  - The TS state is removed; BB goes directly to L1.
  - GRANT_TS is tied 0 and TS_REQ is ignored.
  - PKT_TYPE never takes 8'h20.

## Structure
- Package t2mi_sched_pkg holds:
  - the state encoding;
  - packet type constants PKT_BB=8'h00, PKT_TS=8'h20, PKT_L1=8'h10.
- One sub-module, t2mi_sched_watchdog: a timeout counter with clear/enable inputs and an expire output, parameterised by TIMEOUT_CYCLES.

## Test plan
- Basic frame, TIMESTAMP_EN defined: plp_num_blocks=3, num_t2_frames=2, all REQ high, DONE 4 cycles after each grant.
  - Expect the grant order BB,BB,BB,TS,L1, repeating.
  - PKT_COUNT runs 0..9 across the two frames.
  - FRAME_IDX runs 0,1,0; SUPERFRAME_IDX becomes 1 after 10 packets.
- Zero blocks: plp_num_blocks=0. Expect only TS and L1 grants per frame, with FRAME_IDX incrementing every 2 packets.
- Timeout: TIMEOUT_CYCLES=16, BB granted, DONE never sent.
  - Expect the grant to drop after 16 cycles, TIMEOUT_ERR=1, and PKT_COUNT unchanged.
  - The next BB grant follows.
- START dropped mid-frame while GRANT_BB is high, with DONE 2 cycles later.
  - Expect the grant low the cycle after DONE, then IDLE, with FRAME_IDX=0.
  - PKT_COUNT is retained and continues on restart.
- Stray and asynchronous events:
  - PKT_DONE pulses with no grant cause no counter change.
  - Asserting RST mid-grant clears all outputs to reset values asynchronously.
- T2MI_TIMESTAMP_EN undefined: plp_num_blocks=2, TS_REQ held high. Expect BB,BB,L1 and GRANT_TS never high.
